// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared memory-interface codes for the cache/memory arbiter.
// The `define block is the common header the caches and the memory model
// use for op/status/data-type codes; the localparams and the state enum
// below wrap those codes as typed constants for the arbiter RTL.
// No ports (package).

`ifndef MEM_DEFINES_SVH
`define MEM_DEFINES_SVH
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`define MEM_RESTING       2'b00
`define MEM_INST_FINISHED 2'b01
`define MEM_DATA_FINISHED 2'b10
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define EIGHT_BYTE        3'b011
`define MEM_ARB_IDLE      2'b00
`define MEM_ARB_ISSUE     2'b01
`define MEM_ARB_WAIT      2'b10
`define MEM_ARB_DONE      2'b11
`endif

package mem_arbiter_pkg;

  localparam logic [1:0] MEM_NOP           = `MEM_NOP;
  localparam logic [1:0] MEM_READ          = `MEM_READ;
  localparam logic [1:0] MEM_WRITE         = `MEM_WRITE;
  localparam logic [1:0] MEM_INST_FINISHED = `MEM_INST_FINISHED;
  localparam logic [1:0] MEM_DATA_FINISHED = `MEM_DATA_FINISHED;
  localparam logic [2:0] FOUR_BYTE         = `FOUR_BYTE;

  typedef enum logic [1:0] {
    ARB_IDLE  = `MEM_ARB_IDLE,
    ARB_ISSUE = `MEM_ARB_ISSUE,
    ARB_WAIT  = `MEM_ARB_WAIT,
    ARB_DONE  = `MEM_ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
// Grant selection for the memory arbiter: data requests win by default, but
// once STARVE_LIMIT data grants have been given back to back while an
// instruction fetch was waiting, the fetch is granted next.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   idle      - arbiter is in IDLE; grants and counter updates only happen here
//   i_req     - instruction fetch pending
//   d_req     - data request pending
//   grant_i   - combinational: grant the instruction side this cycle
//   grant_d   - combinational: grant the data side this cycle

module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (idle) begin
      if (d_req && (!i_req || starve_cnt < LIMIT)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Counts data grants handed out while a fetch was left waiting; any cycle
  // in IDLE without a pending fetch, or a fetch grant, forgets the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (grant_i || !i_req) begin
        starve_cnt <= '0;
      end else if (grant_d && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbiter/sequencer between the instruction cache, the data cache and the
// single-port main memory. Grants one side, splits data requests into 4-byte
// beats (one ISSUE cycle plus one WAIT cycle per beat), returns read beats to
// the data cache and finishes every transfer with a one-cycle done pulse.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   i_req, i_addr                 - instruction fetch request / byte address
//   i_done, i_rdata               - fetch done pulse / fetched word
//   d_req, d_rw, d_addr, d_length - data request, 0=read 1=write, base, beats
//   d_data_type, d_wdata          - single-beat write size, packed write beats
//   d_beat_valid, d_beat_idx,
//   d_rdata, d_done               - returned read beat, data done pulse
//   i/d_cache_mem_vis_signal/addr - memory op and beat address per side
//   mem_written_data, mem_data_type - write beat and size to memory
//   mem_data, mem_status          - memory read data and completion status

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH       = 20,
  parameter int DATA_LEN         = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req,
  input  logic [ADDR_WIDTH-1:0]           i_addr,
  output logic                            i_done,
  output logic [DATA_LEN-1:0]             i_rdata,
  input  logic                            d_req,
  input  logic                            d_rw,
  input  logic [ADDR_WIDTH-1:0]           d_addr,
  input  logic [ENTRY_INDEX_SIZE:0]       d_length,
  input  logic [2:0]                      d_data_type,
  input  logic [DATA_LEN*VECTOR_SIZE-1:0] d_wdata,
  output logic                            d_beat_valid,
  output logic [ENTRY_INDEX_SIZE-1:0]     d_beat_idx,
  output logic [DATA_LEN-1:0]             d_rdata,
  output logic                            d_done,
  output logic [1:0]                      i_cache_mem_vis_signal,
  output logic [1:0]                      d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]           i_cache_mem_vis_addr,
  output logic [ADDR_WIDTH-1:0]           d_cache_mem_vis_addr,
  output logic [DATA_LEN-1:0]             mem_written_data,
  output logic [2:0]                      mem_data_type,
  input  logic [DATA_LEN-1:0]             mem_data,
  input  logic [1:0]                      mem_status
);

  localparam logic [ENTRY_INDEX_SIZE:0] ONE_LEN = 1;

  arb_state_t state, state_next;

  logic                            grant_i, grant_d;
  logic                            is_data;
  logic                            rw;
  logic [ADDR_WIDTH-1:0]           base_addr;
  logic [ENTRY_INDEX_SIZE:0]       length;
  logic [2:0]                      data_type;
  logic [DATA_LEN*VECTOR_SIZE-1:0] wbeats;
  logic [ENTRY_INDEX_SIZE-1:0]     beat;
  logic [ADDR_WIDTH-1:0]           beat_addr;
  logic                            status_match;
  logic                            last_beat;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk    (clk),
    .rst    (rst),
    .idle   (state == ARB_IDLE),
    .i_req  (i_req),
    .d_req  (d_req),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // Beat addresses step by 4 bytes and wrap naturally at the address width.
  assign beat_addr    = base_addr + ADDR_WIDTH'({beat, 2'b00});
  assign status_match = (mem_status == (is_data ? MEM_DATA_FINISHED : MEM_INST_FINISHED));
  assign last_beat    = ({1'b0, beat} == (length - ONE_LEN));

  // Request fields are captured at grant time so the requester's inputs are
  // free to change; a zero length is stored as one beat, and fetches are
  // always a single beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      beat      <= '0;
      is_data   <= 1'b0;
      rw        <= 1'b0;
      base_addr <= '0;
      length    <= '0;
      data_type <= '0;
      wbeats    <= '0;
      i_rdata   <= '0;
    end else begin
      state <= state_next;
      case (state)
        ARB_IDLE: begin
          if (grant_i || grant_d) begin
            is_data   <= grant_d;
            rw        <= grant_d & d_rw;
            base_addr <= grant_d ? d_addr : i_addr;
            length    <= (!grant_d || d_length == '0) ? ONE_LEN : d_length;
            data_type <= d_data_type;
            wbeats    <= d_wdata;
            beat      <= '0;
          end
        end
        ARB_WAIT: begin
          if (status_match) begin
            if (!is_data) begin
              i_rdata <= mem_data;
            end else if (!last_beat) begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and all memory/requester outputs. Everything is held at zero
  // while reset is asserted so the outputs are quiet from the reset cycle on.
  always_comb begin
    state_next             = state;
    i_cache_mem_vis_signal = MEM_NOP;
    d_cache_mem_vis_signal = MEM_NOP;
    i_cache_mem_vis_addr   = '0;
    d_cache_mem_vis_addr   = '0;
    mem_written_data       = '0;
    mem_data_type          = '0;
    i_done                 = 1'b0;
    d_done                 = 1'b0;
    d_beat_valid           = 1'b0;
    d_beat_idx             = '0;
    d_rdata                = '0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (grant_i || grant_d) begin
            state_next = ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state_next = ARB_WAIT;
          if (is_data) begin
            d_cache_mem_vis_signal = rw ? MEM_WRITE : MEM_READ;
            d_cache_mem_vis_addr   = beat_addr;
            mem_data_type          = (length == ONE_LEN) ? data_type : FOUR_BYTE;
            if (rw) begin
              mem_written_data = wbeats[beat*DATA_LEN +: DATA_LEN];
            end
          end else begin
            i_cache_mem_vis_signal = MEM_READ;
            i_cache_mem_vis_addr   = beat_addr;
          end
        end
        ARB_WAIT: begin
          if (status_match) begin
            if (is_data && !rw) begin
              d_beat_valid = 1'b1;
              d_beat_idx   = beat;
              d_rdata      = mem_data;
            end
            state_next = (!is_data || last_beat) ? ARB_DONE : ARB_ISSUE;
          end
        end
        ARB_DONE: begin
          state_next = ARB_IDLE;
          if (is_data) begin
            d_done = 1'b1;
          end else begin
            i_done = 1'b1;
          end
        end
        default: begin
          state_next = ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter with a one-cycle-latency byte-addressed memory model
// (big-endian: the lowest address is the most significant byte of a word).
// Transfers come from a table of requests with hand-computed done cycles and
// first-beat data; every cycle of a transfer is compared against the expected
// output picture. Contention, mid-transfer reset and address wrap are covered
// by hand-written sequences and table rows.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 20;
  localparam int DL  = 32;
  localparam int VS  = 8;
  localparam int EIS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_done;
  logic [DL-1:0]   i_rdata;
  logic            d_req;
  logic            d_rw;
  logic [AW-1:0]   d_addr;
  logic [EIS:0]    d_length;
  logic [2:0]      d_data_type;
  logic [DL*VS-1:0] d_wdata;
  logic            d_beat_valid;
  logic [EIS-1:0]  d_beat_idx;
  logic [DL-1:0]   d_rdata;
  logic            d_done;
  logic [1:0]      i_sig;
  logic [1:0]      d_sig;
  logic [AW-1:0]   i_vaddr;
  logic [AW-1:0]   d_vaddr;
  logic [DL-1:0]   mem_written_data;
  logic [2:0]      mem_data_type;
  logic [DL-1:0]   mem_data = '0;
  logic [1:0]      mem_status = `MEM_RESTING;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_req                 (i_req),
    .i_addr                (i_addr),
    .i_done                (i_done),
    .i_rdata               (i_rdata),
    .d_req                 (d_req),
    .d_rw                  (d_rw),
    .d_addr                (d_addr),
    .d_length              (d_length),
    .d_data_type           (d_data_type),
    .d_wdata               (d_wdata),
    .d_beat_valid          (d_beat_valid),
    .d_beat_idx            (d_beat_idx),
    .d_rdata               (d_rdata),
    .d_done                (d_done),
    .i_cache_mem_vis_signal(i_sig),
    .d_cache_mem_vis_signal(d_sig),
    .i_cache_mem_vis_addr  (i_vaddr),
    .d_cache_mem_vis_addr  (d_vaddr),
    .mem_written_data      (mem_written_data),
    .mem_data_type         (mem_data_type),
    .mem_data              (mem_data),
    .mem_status            (mem_status)
  );

  // Memory model: byte store plus one-cycle registered status/data.
  logic [7:0] memBytes [int];

  function automatic logic [7:0] rdByte(logic [AW-1:0] a);
    if (memBytes.exists(int'(a))) return memBytes[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rdWord(logic [AW-1:0] a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = rdByte(a + AW'(j));
    return w;
  endfunction

  task automatic wrMem(input logic [AW-1:0] a, input logic [31:0] w, input logic [2:0] dt);
    int n;
    n = (dt == `ONE_BYTE) ? 1 : (dt == `TWO_BYTE) ? 2 : 4;
    for (int j = 0; j < n; j++) memBytes[int'(a + AW'(j))] = w[31-8*j -: 8];
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] w);
    wrMem(a, w, `FOUR_BYTE);
  endtask

  always @(posedge clk) begin
    mem_status <= `MEM_RESTING;
    if (i_sig == `MEM_READ) begin
      mem_data   <= rdWord(i_vaddr);
      mem_status <= `MEM_INST_FINISHED;
    end else if (d_sig == `MEM_READ) begin
      mem_data   <= rdWord(d_vaddr);
      mem_status <= `MEM_DATA_FINISHED;
    end else if (d_sig == `MEM_WRITE) begin
      wrMem(d_vaddr, mem_written_data, mem_data_type);
      mem_status <= `MEM_DATA_FINISHED;
    end
  end

  // Output picture compared every cycle.
  typedef struct packed {
    logic          iDone;
    logic [31:0]   iRdata;
    logic          bValid;
    logic [2:0]    bIdx;
    logic [31:0]   dRdata;
    logic          dDone;
    logic [1:0]    iSig;
    logic [1:0]    dSig;
    logic [AW-1:0] iAddr;
    logic [AW-1:0] dAddr;
    logic [31:0]   wData;
    logic [2:0]    dType;
  } outs_t;

  typedef struct {
    logic          isData;
    logic          rw;
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic [2:0]    dtype;
    logic [31:0]   w0;
    logic [31:0]   w1;
    int            expDone;
    logic          checkFirst;
    logic [31:0]   expFirst;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastIWord = '0;
  xfer_t       tbl [10];

  function automatic xfer_t mkX(logic isData, logic rw, logic [AW-1:0] addr, logic [3:0] len,
                                logic [2:0] dtype, logic [31:0] w0, logic [31:0] w1,
                                int expDone, logic checkFirst, logic [31:0] expFirst);
    xfer_t x;
    x.isData = isData; x.rw = rw; x.addr = addr; x.len = len; x.dtype = dtype;
    x.w0 = w0; x.w1 = w1; x.expDone = expDone; x.checkFirst = checkFirst; x.expFirst = expFirst;
    return x;
  endfunction

  function automatic logic [31:0] wBeat(xfer_t x, int k);
    if (k == 0) return x.w0;
    if (k == 1) return x.w1;
    return 32'hC0DE0000 | 32'(k);
  endfunction

  function automatic outs_t sampleOuts();
    outs_t o;
    o.iDone = i_done; o.iRdata = i_rdata; o.bValid = d_beat_valid; o.bIdx = d_beat_idx;
    o.dRdata = d_rdata; o.dDone = d_done; o.iSig = i_sig; o.dSig = d_sig;
    o.iAddr = i_vaddr; o.dAddr = d_vaddr; o.wData = mem_written_data; o.dType = mem_data_type;
    return o;
  endfunction

  function automatic outs_t idleOuts();
    outs_t o;
    o = '0;
    o.iRdata = lastIWord;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(xfer_t x);
    i_req       = !x.isData;
    i_addr      = x.isData ? '0 : x.addr;
    d_req       = x.isData;
    d_rw        = x.rw;
    d_addr      = x.isData ? x.addr : '0;
    d_length    = x.len;
    d_data_type = x.dtype;
    for (int k = 0; k < VS; k++) d_wdata[k*DL +: DL] = wBeat(x, k);
  endtask

  task automatic dropRequests();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Runs one transfer from an IDLE cycle (cycle 0) and checks every cycle up
  // to the done pulse, then the following IDLE cycle.
  task automatic runXfer(xfer_t x, int idx);
    int    n;
    int    doneCyc;
    int    seenDone;
    int    k;
    outs_t exp;
    outs_t act;
    n        = (!x.isData || x.len == 0) ? 1 : int'(x.len);
    doneCyc  = 2 * n + 1;
    seenDone = -1;
    applyStimulus(x);
    for (int c = 1; c <= doneCyc; c++) begin
      stepCycle();
      exp = idleOuts();
      k   = (c - 1) / 2;
      if (c == doneCyc) begin
        if (x.isData) begin
          exp.dDone = 1'b1;
        end else begin
          lastIWord  = rdWord(x.addr);
          exp.iDone  = 1'b1;
          exp.iRdata = lastIWord;
        end
      end else if (c % 2 == 1) begin
        if (x.isData) begin
          exp.dSig  = x.rw ? `MEM_WRITE : `MEM_READ;
          exp.dAddr = x.addr + AW'(4 * k);
          exp.dType = (n == 1) ? x.dtype : `FOUR_BYTE;
          exp.wData = x.rw ? wBeat(x, k) : 32'h0;
        end else begin
          exp.iSig  = `MEM_READ;
          exp.iAddr = x.addr;
        end
      end else if (x.isData && !x.rw) begin
        exp.bValid = 1'b1;
        exp.bIdx   = 3'(k);
        exp.dRdata = rdWord(x.addr + AW'(4 * k));
      end
      act = sampleOuts();
      checkOutput($sformatf("xfer%0d_cyc%0d", idx, c), 160'(act), 160'(exp));
      if ((act.iDone || act.dDone) && seenDone < 0) seenDone = c;
      if (x.checkFirst && x.isData && c == 2)
        checkOutput($sformatf("xfer%0d_first_beat", idx), 160'(act.dRdata), 160'(x.expFirst));
      if (x.checkFirst && !x.isData && c == 3)
        checkOutput($sformatf("xfer%0d_fetch_word", idx), 160'(act.iRdata), 160'(x.expFirst));
    end
    checkOutput($sformatf("xfer%0d_done_cycle", idx), 160'(seenDone), 160'(x.expDone));
    stepCycle();
    dropRequests();
    checkOutput($sformatf("xfer%0d_idle_gap", idx), 160'(sampleOuts()), 160'(idleOuts()));
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] gotOrder [6];
    logic [7:0] expOrder [6];
    int         grants;
    int         doneSeen;

    expOrder = '{"D", "D", "D", "D", "I", "D"};
    for (int g = 0; g < 6; g++) gotOrder[g] = 8'h00;

    preload(20'h00010, 32'h13000093);
    preload(20'h00020, 32'h11223344);
    preload(20'h00100, 32'hA0A1A2A3);
    preload(20'h00104, 32'hA4A5A6A7);
    preload(20'h00108, 32'hA8A9AAAB);
    preload(20'h0010C, 32'hACADAEAF);
    preload(20'hFFFFC, 32'hDEADBEEF);
    preload(20'h00000, 32'h01020304);

    //             isData rw addr      len   dtype       w0            w1            done chk first
    tbl[0] = mkX(1'b0, 1'b0, 20'h00010, 4'd1, `ONE_BYTE,  32'h0,        32'h0,         3, 1'b1, 32'h13000093);
    tbl[1] = mkX(1'b1, 1'b0, 20'h00100, 4'd4, `ONE_BYTE,  32'h0,        32'h0,         9, 1'b1, 32'hA0A1A2A3);
    tbl[2] = mkX(1'b1, 1'b1, 20'h00020, 4'd1, `ONE_BYTE,  32'hAB000000, 32'h0,         3, 1'b0, 32'h0);
    tbl[3] = mkX(1'b1, 1'b0, 20'h00020, 4'd1, `FOUR_BYTE, 32'h0,        32'h0,         3, 1'b1, 32'hAB223344);
    tbl[4] = mkX(1'b1, 1'b0, 20'hFFFFC, 4'd2, `FOUR_BYTE, 32'h0,        32'h0,         5, 1'b1, 32'hDEADBEEF);
    tbl[5] = mkX(1'b1, 1'b0, 20'h00104, 4'd0, `TWO_BYTE,  32'h0,        32'h0,         3, 1'b1, 32'hA4A5A6A7);
    tbl[6] = mkX(1'b1, 1'b1, 20'h00300, 4'd2, `ONE_BYTE,  32'h11112222, 32'h33334444,  5, 1'b0, 32'h0);
    tbl[7] = mkX(1'b1, 1'b0, 20'h00300, 4'd2, `FOUR_BYTE, 32'h0,        32'h0,         5, 1'b1, 32'h11112222);
    tbl[8] = mkX(1'b0, 1'b0, 20'h00104, 4'd1, `ONE_BYTE,  32'h0,        32'h0,         3, 1'b1, 32'hA4A5A6A7);
    tbl[9] = mkX(1'b1, 1'b0, 20'h00100, 4'd8, `EIGHT_BYTE,32'h0,        32'h0,        17, 1'b1, 32'hA0A1A2A3);

    rst = 1'b1;
    dropRequests();
    i_addr = '0; d_rw = 1'b0; d_addr = '0; d_length = '0; d_data_type = '0; d_wdata = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset_asserted", 160'(sampleOuts()), 160'(idleOuts()));
    rst = 1'b0;
    stepCycle();
    checkOutput("reset_released", 160'(sampleOuts()), 160'(idleOuts()));

    for (int t = 0; t < 10; t++) runXfer(tbl[t], t);

    // Contention: both sides hold their request; data wins STARVE_LIMIT
    // times, then the fetch gets through, then data again.
    i_req = 1'b1; i_addr = 20'h00010;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 20'h00100; d_length = 4'd1; d_data_type = `FOUR_BYTE;
    grants = 0;
    for (int c = 0; c < 100 && grants < 6; c++) begin
      stepCycle();
      if (i_sig == `MEM_READ) begin
        gotOrder[grants] = "I";
        grants++;
      end else if (d_sig != `MEM_NOP) begin
        gotOrder[grants] = "D";
        grants++;
      end
    end
    for (int g = 0; g < 6; g++)
      checkOutput($sformatf("contention_grant%0d", g), 160'(gotOrder[g]), 160'(expOrder[g]));
    dropRequests();
    lastIWord = 32'h13000093;
    for (int c = 0; c < 6; c++) stepCycle();
    checkOutput("contention_settled", 160'(sampleOuts()), 160'(idleOuts()));

    // Reset during the WAIT of beat 2 of an 8-beat read.
    applyStimulus(tbl[9]);
    for (int c = 0; c < 6; c++) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    dropRequests();
    lastIWord = 32'h0;
    checkOutput("reset_midxfer_outputs", 160'(sampleOuts()), 160'(idleOuts()));
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      stepCycle();
      if (d_done || d_beat_valid || d_sig != `MEM_NOP) doneSeen++;
    end
    checkOutput("reset_midxfer_no_activity", 160'(doneSeen), 160'(0));

    runXfer(tbl[0], 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
